// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg: shared constants, state type and sizing helper for the LUT config loader
package lut_cfg_pkg;
  localparam int MASK_W = 8;
  localparam logic [MASK_W-1:0] CKSUM_SEED_DEF = 8'h5A;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK} lut_cfg_state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lut_cfg_shadow.sv
// lut_cfg_shadow: staged mask bytes plus the active mask bank, swapped in as one word on commit
module lut_cfg_shadow
  import lut_cfg_pkg::*;
#(
  parameter int NUM_LUTS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [IDX_W-1:0]           idx,
  input  logic [MASK_W-1:0]          data,
  input  logic                       commit,
  output logic [NUM_LUTS*MASK_W-1:0] masks
);
  logic [NUM_LUTS*MASK_W-1:0] shadow_q, shadow_d, masks_q, masks_d;
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_LUTS; i++)
      shadow_d[MASK_W*i +: MASK_W] = (we && idx == IDX_W'(i)) ? data : shadow_q[MASK_W*i +: MASK_W];
    masks_d = commit ? shadow_q : masks_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      masks_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      masks_q  <= masks_d;
    end
  end
  assign masks = masks_q;
endmodule

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: byte-stream loader that commits LUT masks only after a matching XOR checksum
module lut_cfg_loader
  import lut_cfg_pkg::*;
#(
  parameter int                NUM_LUTS   = 4,
  parameter logic [MASK_W-1:0] CKSUM_SEED = CKSUM_SEED_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_valid,
  input  logic [MASK_W-1:0]          in_data,
  output logic                       in_ready,
  output logic [NUM_LUTS*MASK_W-1:0] masks,
  output logic                       cfg_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);
  localparam int IDX_W = idx_w(NUM_LUTS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LUTS - 1);
  lut_cfg_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [MASK_W-1:0] cksum_q, cksum_d;
  logic err_q, err_d, cfg_valid_q, cfg_valid_d, done_q, done_d;
  logic acc, launch, last, we, check_acc, commit;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cksum_q     <= CKSUM_SEED;
      err_q       <= 1'b0;
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cksum_q     <= cksum_d;
      err_q       <= err_d;
      cfg_valid_q <= cfg_valid_d;
      done_q      <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = abort ? IDLE : (acc && last) ? CHECK : LOAD;
      CHECK:   state_d = (abort || acc) ? IDLE : CHECK;
      default: state_d = IDLE;
    endcase
  end
  // abort masks in_ready, so an accept can never coincide with an abort
  always_comb begin
    busy      = state_q != IDLE;
    in_ready  = busy && !abort;
    acc       = in_valid && in_ready;
    launch    = state_q == IDLE && start;
    last      = idx_q == LAST;
    we        = acc && state_q == LOAD;
    check_acc = acc && state_q == CHECK;
    commit    = check_acc && in_data == cksum_q;
  end
  always_comb begin
    idx_d       = launch ? '0 : (we && !last) ? idx_q + 1'b1 : idx_q;
    cksum_d     = launch ? CKSUM_SEED : we ? cksum_q ^ in_data : cksum_q;
    err_d       = launch ? 1'b0 : (check_acc && !commit) ? 1'b1 : err_q;
    cfg_valid_d = cfg_valid_q || commit;
    done_d      = commit;
  end
  lut_cfg_shadow #(.NUM_LUTS(NUM_LUTS), .IDX_W(IDX_W)) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .idx    (idx_q),
    .data   (in_data),
    .commit (commit),
    .masks  (masks)
  );
  assign cfg_valid = cfg_valid_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader: randomized loads against a reference model, scoreboarded on done / err events
module tb_lut_cfg_loader;
  localparam int N = 4;
  localparam logic [7:0] SEED = 8'h5A;
  typedef struct packed {
    logic [N*8-1:0] m;
    logic           v;
    logic           d;
    logic           e;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, cfg_valid, busy, done, err;
  logic [N*8-1:0] masks;

  int checks = 0, errors = 0;
  exp_t sb[$];
  logic [N*8-1:0] model_m = '0;
  logic model_v = 1'b0;
  logic err_prev = 1'b0;

  lut_cfg_loader #(.NUM_LUTS(N), .CKSUM_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .masks(masks), .cfg_valid(cfg_valid),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every done pulse or err rising edge is one finished load
  always @(negedge clk) begin
    if (!rst && (done || (err && !err_prev))) begin
      if (sb.size() == 0) chk("unexpected_event", 64'(done), 64'(0));
      else begin
        exp_t x;
        x = sb.pop_front();
        chk("ev_masks", 64'(masks), 64'(x.m));
        chk("ev_cfg_valid", 64'(cfg_valid), 64'(x.v));
        chk("ev_done", 64'(done), 64'(x.d));
        chk("ev_err", 64'(err), 64'(x.e));
      end
    end
    err_prev = err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n;
    repeat ($urandom_range(0, gap_max)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_abort();
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'(0));
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_masks", 64'(masks), 64'(model_m));
    chk("abort_cfg_valid", 64'(cfg_valid), 64'(model_v));
  endtask

  // abort_at: abort before byte k (-1 none); pulse_at: pulse start before byte k (-1 none)
  task automatic do_load(input logic [N*8-1:0] w, input logic [7:0] ck,
                         input int abort_at, input int pulse_at, input int gap_max);
    logic [7:0] x;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= N; i++) begin
      if (i == abort_at) begin
        do_abort();
        return;
      end
      if (i == pulse_at) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      if (i == N) begin
        x = SEED;
        for (int j = 0; j < N; j++) x ^= w[8*j +: 8];
        if (x == ck) begin
          model_m = w;
          model_v = 1'b1;
          sb.push_back('{m: w, v: 1'b1, d: 1'b1, e: 1'b0});
        end else
          sb.push_back('{m: model_m, v: model_v, d: 1'b0, e: 1'b1});
        send_byte(ck, gap_max);
      end else
        send_byte(w[8*i +: 8], gap_max);
    end
    chk("end_busy", 64'(busy), 64'(0));
  endtask

  function automatic logic [7:0] good_ck(input logic [N*8-1:0] w);
    logic [7:0] x = SEED;
    for (int j = 0; j < N; j++) x ^= w[8*j +: 8];
    return x;
  endfunction

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_masks", 64'(masks), 64'(0));
    chk("rst_cfg_valid", 64'(cfg_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'(0));
    do_load(32'hFE80E896, 8'h5B, -1, -1, 0);
    chk("bad_masks", 64'(masks), 64'(0));
    do_load(32'hFE80E896, 8'h5A, -1, -1, 0);
    chk("good_masks", 64'(masks), 64'hFE80E896);
    do_load(32'hFE80E896, 8'h5A, -1, -1, 4);
    do_load(32'h12345678, 8'h00, 2, -1, 1);
    do_load(32'hA5C3_0F11, good_ck(32'hA5C30F11), -1, -1, 2);
    do_load(32'hF00FFF00, 8'h5A, -1, -1, 0);
    chk("reconf_masks", 64'(masks), 64'hF00FFF00);
    chk("reconf_cfg_valid", 64'(cfg_valid), 64'(1));
    do_load(32'h0BADBEEF, 8'h00, 3, -1, 0);
    chk("held_cfg_valid", 64'(cfg_valid), 64'(1));
    do_load(32'h11223344, good_ck(32'h11223344), -1, 2, 1);
    chk("start_busy_masks", 64'(masks), 64'h11223344);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h77, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_m = '0;
    model_v = 1'b0;
    chk("midrst_masks", 64'(masks), 64'(0));
    chk("midrst_cfg_valid", 64'(cfg_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_err", 64'(err), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    for (int k = 0; k < 40; k++) begin
      logic [N*8-1:0] w;
      logic [7:0] ck;
      w  = 32'($urandom);
      ck = good_ck(w) ^ (($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      do_load(w, ck, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N)) : -1,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, N)) : -1, 3);
      chk("rand_masks", 64'(masks), 64'(model_m));
      chk("rand_cfg_valid", 64'(cfg_valid), 64'(model_v));
    end
    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
